freq_meter: RTL

Gated edge-counting frequency meter, the measuring counterpart to the programmable divider: the divider turns a number into a frequency, this block turns a frequency back into a number. It counts rising edges of an asynchronous input `sig_in` over a programmable window of `clk` cycles and reports the count with a one-cycle valid strobe. Typical use is closed-loop checking of divider output: f_sig = count * f_clk / gate_len.

---
 rtl/freq_meter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// freq_meter: gated edge-counting frequency meter.
// Counts rising edges of the asynchronous input sig_in over a window of
// gate_len clk cycles and reports the result with a one-cycle valid strobe.
// f_sig = count * f_clk / gate_len.
//
// Ports:
//   clk        system clock, all state changes on posedge
//   rst_n      asynchronous active-low reset
//   sig_in     signal under measurement (asynchronous to clk)
//   start      begin a measurement (honoured only in IDLE)
//   continuous re-arm automatically at the end of each window
//   abort      cancel the measurement in progress, no result produced
//   gate_len   window length in clk cycles (0 treated as 1), latched at window start
//   busy       high while a window is open
//   count      last completed edge count, saturating, held until the next result
//   valid      one-cycle strobe when count/overflow update
//   overflow   last result saturated
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no window open, waiting for start
// ST_COUNT | window open, counting synchronized rising edges of sig_in
module freq_meter #(
  parameter int COUNT_W = 32,
  parameter int GATE_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sig_in,
  input  logic               start,
  input  logic               continuous,
  input  logic               abort,
  input  logic [GATE_W-1:0]  gate_len,
  output logic               busy,
  output logic [COUNT_W-1:0] count,
  output logic               valid,
  output logic               overflow
);

  typedef enum logic {ST_IDLE, ST_COUNT} state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic               s1, s2, s3;
  logic               sig_edge;
  logic [GATE_W-1:0]  gl;
  logic [GATE_W-1:0]  gl_next;
  logic [GATE_W-1:0]  gate_ctr;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] cnt_final;
  logic               ovf;
  logic               cnt_sat;
  logic               last_cycle;

  // s1/s2 resolve metastability; s3 is only a delay for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sig_edge   = s2 & ~s3;
  assign gl_next    = (gate_len == '0) ? GATE_W'(1) : gate_len;
  assign cnt_sat    = (cnt == CNT_MAX);
  assign last_cycle = (gate_ctr == gl - GATE_W'(1));
  // The edge seen in the final window cycle still belongs to this window.
  assign cnt_final  = (sig_edge && !cnt_sat) ? cnt + COUNT_W'(1) : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      gl       <= '0;
      gate_ctr <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            gl       <= gl_next;
            gate_ctr <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (last_cycle) begin
            count    <= cnt_final;
            overflow <= ovf | (sig_edge & cnt_sat);
            valid    <= 1'b1;
            if (continuous) begin
              // Back-to-back windows: no dead cycle between them.
              gl       <= gl_next;
              gate_ctr <= '0;
              cnt      <= '0;
              ovf      <= 1'b0;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            gate_ctr <= gate_ctr + GATE_W'(1);
            if (sig_edge) begin
              if (cnt_sat) ovf <= 1'b1;
              else         cnt <= cnt + COUNT_W'(1);
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
